// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master round-robin Avalon-MM arbiter with bounded hold
module mem_arbiter #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int MAX_HOLD   = 8,
  parameter int HOLD_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] m0_address,
  input  logic [BE_WIDTH-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_WIDTH-1:0] m0_writedata,
  output logic [DATA_WIDTH-1:0] m0_readdata,
  output logic                  m0_waitrequest,
  input  logic [ADDR_WIDTH-1:0] m1_address,
  input  logic [BE_WIDTH-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_WIDTH-1:0] m1_writedata,
  output logic [DATA_WIDTH-1:0] m1_readdata,
  output logic                  m1_waitrequest,
  output logic [ADDR_WIDTH-1:0] s_address,
  output logic [BE_WIDTH-1:0]   s_byteenable,
  output logic                  s_read,
  output logic                  s_write,
  output logic [DATA_WIDTH-1:0] s_writedata,
  input  logic [DATA_WIDTH-1:0] s_readdata,
  input  logic                  s_waitrequest,
  output logic [1:0]            grant,
  output logic                  busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT0, ST_GRANT1} state_t;

  localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(MAX_HOLD - 1);

  state_t                r_state;
  state_t                w_next_state;
  state_t                w_other_state;
  logic                  r_last_grant;
  logic [HOLD_WIDTH-1:0] r_hold_cnt;
  logic [HOLD_WIDTH-1:0] w_next_hold;
  logic                  w_req0;
  logic                  w_req1;
  logic                  w_req_own;
  logic                  w_req_other;
  logic                  w_done;
  logic                  w_hold_max;

  assign w_req0 = m0_read | m0_write;
  assign w_req1 = m1_read | m1_write;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_hold_cnt   <= '0;
    end else begin
      r_state    <= w_next_state;
      r_hold_cnt <= w_next_hold;
      if (w_next_state == ST_GRANT0 && r_state != ST_GRANT0) r_last_grant <= 1'b0;
      if (w_next_state == ST_GRANT1 && r_state != ST_GRANT1) r_last_grant <= 1'b1;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_next_hold   = r_hold_cnt;
    w_req_own     = (r_state == ST_GRANT1) ? w_req1 : w_req0;
    w_req_other   = (r_state == ST_GRANT1) ? w_req0 : w_req1;
    w_other_state = (r_state == ST_GRANT1) ? ST_GRANT0 : ST_GRANT1;
    w_done        = w_req_own & ~s_waitrequest;
    w_hold_max    = (r_hold_cnt == HOLD_LAST);
    case (r_state)
      ST_IDLE: begin
        w_next_hold = '0;
        if (w_req0 && w_req1)  w_next_state = r_last_grant ? ST_GRANT0 : ST_GRANT1;
        else if (w_req0)       w_next_state = ST_GRANT0;
        else if (w_req1)       w_next_state = ST_GRANT1;
      end
      ST_GRANT0, ST_GRANT1: begin
        // Stalled cycles fall through untouched, so an in-flight transfer is never re-granted.
        if (!w_req_own) begin
          w_next_state = w_req_other ? w_other_state : ST_IDLE;
          w_next_hold  = '0;
        end else if (w_done && w_req_other && w_hold_max) begin
          w_next_state = w_other_state;
          w_next_hold  = '0;
        end else if (w_done && !w_hold_max) begin
          w_next_hold = r_hold_cnt + 1'b1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    s_address      = '0;
    s_byteenable   = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    m0_readdata    = '0;
    m1_readdata    = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    grant          = 2'b00;
    busy           = (r_state != ST_IDLE);
    case (r_state)
      ST_GRANT0: begin
        s_address      = m0_address;
        s_byteenable   = m0_byteenable;
        s_read         = m0_read;
        s_write        = m0_write;
        s_writedata    = m0_writedata;
        m0_readdata    = s_readdata;
        m0_waitrequest = s_waitrequest;
        grant          = 2'b01;
      end
      ST_GRANT1: begin
        s_address      = m1_address;
        s_byteenable   = m1_byteenable;
        s_read         = m1_read;
        s_write        = m1_write;
        s_writedata    = m1_writedata;
        m1_readdata    = s_readdata;
        m1_waitrequest = s_waitrequest;
        grant          = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [19:0] m0_address, m1_address, s_address;
  logic [1:0]  m0_byteenable, m1_byteenable, s_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write, s_read, s_write;
  logic [15:0] m0_writedata, m1_writedata, s_writedata;
  logic [15:0] m0_readdata, m1_readdata, s_readdata;
  logic        m0_waitrequest, m1_waitrequest, s_waitrequest;
  logic [1:0]  grant;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_readdata(m0_readdata),
    .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_readdata(m1_readdata),
    .m1_waitrequest(m1_waitrequest),
    .s_address(s_address), .s_byteenable(s_byteenable), .s_read(s_read),
    .s_write(s_write), .s_writedata(s_writedata), .s_readdata(s_readdata),
    .s_waitrequest(s_waitrequest), .grant(grant), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    m0_address = '0; m1_address = '0; m0_byteenable = 2'b11; m1_byteenable = 2'b11;
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    m0_writedata = '0; m1_writedata = '0;
    s_readdata = 16'hAAAA; s_waitrequest = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_s_read", 32'(s_read), 32'h0);
    check("rst_s_write", 32'(s_write), 32'h0);
    check("rst_m0_wait", 32'(m0_waitrequest), 32'h1);
    check("rst_m1_wait", 32'(m1_waitrequest), 32'h1);
    check("rst_m0_rdata", 32'(m0_readdata), 32'h0);
    check("rst_m1_rdata", 32'(m1_readdata), 32'h0);

    // m1 single write
    m1_write = 1; m1_address = 20'h00010; m1_writedata = 16'hBEEF;
    #1;
    check("w1_idle_wait", 32'(m1_waitrequest), 32'h1);
    tick();
    check("w1_grant", 32'(grant), 32'h2);
    check("w1_busy", 32'(busy), 32'h1);
    check("w1_s_write", 32'(s_write), 32'h1);
    check("w1_s_addr", 32'(s_address), 32'h10);
    check("w1_s_wdata", 32'(s_writedata), 32'hBEEF);
    check("w1_m1_wait", 32'(m1_waitrequest), 32'h0);
    m1_write = 0;
    tick();
    check("w1_release", 32'(grant), 32'h0);

    // both stream from fresh reset: 8 m0 transfers, then 8 m1
    reset = 1; tick(); reset = 0;
    m0_read = 1; m0_address = 20'h00100;
    m1_read = 1; m1_address = 20'h00200;
    tick();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("rr_m0_%0d", i), 32'(grant), 32'h1);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      check($sformatf("rr_m1_%0d", i), 32'(grant), 32'h2);
      tick();
    end
    check("rr_back_m0", 32'(grant), 32'h1);
    m0_read = 0; m1_read = 0;
    tick();
    check("rr_idle", 32'(grant), 32'h0);

    // stalled m1 write while m0 waits (last grant was m0, so m1 wins the tie)
    s_waitrequest = 1; m1_write = 1; m1_address = 20'h00300; m1_writedata = 16'h5A5A;
    m0_read = 1;
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("st_grant_%0d", i), 32'(grant), 32'h2);
      check($sformatf("st_m0_wait_%0d", i), 32'(m0_waitrequest), 32'h1);
      check($sformatf("st_addr_%0d", i), 32'(s_address), 32'h300);
      tick();
    end
    s_waitrequest = 0;
    #1;
    check("st_m1_done", 32'(m1_waitrequest), 32'h0);
    check("st_m0_still", 32'(m0_waitrequest), 32'h1);
    tick();
    m1_write = 0;
    #1;
    check("st_hold", 32'(grant), 32'h2);
    tick();
    check("st_to_m0", 32'(grant), 32'h1);

    // m0 read data path
    m0_address = 20'h00020; s_readdata = 16'h1234;
    #1;
    check("rd_s_read", 32'(s_read), 32'h1);
    check("rd_s_addr", 32'(s_address), 32'h20);
    check("rd_m0_rdata", 32'(m0_readdata), 32'h1234);
    check("rd_m1_rdata", 32'(m1_readdata), 32'h0);
    check("rd_m0_wait", 32'(m0_waitrequest), 32'h0);

    // m0 releases with m1 pending: direct switch, hold count restarts
    m0_read = 0; m1_read = 1; m1_address = 20'h00040;
    #1;
    check("sw_before", 32'(grant), 32'h1);
    check("sw_m1_wait", 32'(m1_waitrequest), 32'h1);
    tick();
    check("sw_busy", 32'(busy), 32'h1);
    m0_read = 1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("sw_m1_%0d", i), 32'(grant), 32'h2);
      tick();
    end
    check("sw_back_m0", 32'(grant), 32'h1);
    m0_read = 0; m1_read = 0;
    tick();
    check("sw_idle", 32'(grant), 32'h0);

    // reset during a stalled m1 write
    s_waitrequest = 1; m1_write = 1; m1_address = 20'h00077;
    tick();
    check("rm_s_write", 32'(s_write), 32'h1);
    reset = 1;
    tick();
    check("rm_s_write_drop", 32'(s_write), 32'h0);
    check("rm_grant", 32'(grant), 32'h0);
    check("rm_m0_wait", 32'(m0_waitrequest), 32'h1);
    check("rm_m1_wait", 32'(m1_waitrequest), 32'h1);
    check("rm_busy", 32'(busy), 32'h0);
    reset = 0; m1_write = 0; s_waitrequest = 0;
    m0_write = 1; m0_address = 20'h00055; m0_writedata = 16'hC0DE;
    #1;
    check("rm_pre_grant", 32'(grant), 32'h0);
    tick();
    check("rm_regrant", 32'(grant), 32'h1);
    check("rm_s_write2", 32'(s_write), 32'h1);
    check("rm_s_wdata", 32'(s_writedata), 32'hC0DE);
    m0_write = 0;
    tick();
    check("rm_final_idle", 32'(grant), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
